// File: rtl/jpeg_idct_transpose_if.sv
// rtl/jpeg_idct_transpose_if.sv - sample stream bus between the IDCT row pass, transpose block and column pass
interface jpeg_idct_transpose_if;
    logic        inport_valid;
    logic [15:0] inport_data;
    logic        inport_ready;
    logic        outport_valid;
    logic [15:0] outport_data;
    logic        outport_last;
    logic        outport_ready;

    // slave: the transpose block (sink of inport, source of outport)
    modport slave (
        input  inport_valid,
        input  inport_data,
        output inport_ready,
        output outport_valid,
        output outport_data,
        output outport_last,
        input  outport_ready
    );

    // master: the surrounding pipeline (source of inport, sink of outport)
    modport master (
        output inport_valid,
        output inport_data,
        input  inport_ready,
        input  outport_valid,
        input  outport_data,
        input  outport_last,
        output outport_ready
    );
endinterface

// File: rtl/jpeg_idct_transpose.sv
// rtl/jpeg_idct_transpose.sv - 8x8 block transpose controller driving an external 64x16 dual-port RAM
module jpeg_idct_transpose #(
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    jpeg_idct_transpose_if.slave         bus,
    output logic [5:0]                   ram_addr0_o,
    output logic [15:0]                  ram_data0_o,
    output logic                         ram_wr0_o,
    output logic [5:0]                   ram_addr1_o,
    input  logic [15:0]                  ram_data1_i
);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      state_q;
    logic [5:0]  wr_cnt_q;
    logic [5:0]  rd_cnt_q;
    logic [5:0]  rd_cnt_d;
    logic        valid_q;
    logic        last_q;
    logic        in_fire;
    logic        out_fire;

    function automatic logic [5:0] read_idx(input logic [5:0] n);
        return TRANSPOSE ? {n[2:0], n[5:3]} : n;
    endfunction

    assign bus.inport_ready  = (state_q == S_FILL) && !flush_i;
    assign in_fire           = bus.inport_valid && bus.inport_ready;
    assign out_fire          = valid_q && bus.outport_ready;

    // Address the sample that will be on the RAM output next cycle; holding it
    // during a stall keeps the registered read data stable.
    assign rd_cnt_d          = out_fire ? rd_cnt_q + 6'd1 : rd_cnt_q;
    assign ram_addr1_o       = read_idx(rd_cnt_d);

    assign ram_wr0_o         = in_fire;
    assign ram_addr0_o       = wr_cnt_q;
    assign ram_data0_o       = bus.inport_data;

    assign bus.outport_valid = valid_q;
    assign bus.outport_data  = ram_data1_i;
    assign bus.outport_last  = last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_FILL;
            wr_cnt_q <= 6'd0;
            rd_cnt_q <= 6'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (flush_i) begin
            state_q  <= S_FILL;
            wr_cnt_q <= 6'd0;
            rd_cnt_q <= 6'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_fire) begin
                        wr_cnt_q <= wr_cnt_q + 6'd1;
                        if (wr_cnt_q == 6'd63) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_fire && (rd_cnt_q == 6'd63)) begin
                        state_q  <= S_FILL;
                        rd_cnt_q <= 6'd0;
                        valid_q  <= 1'b0;
                        last_q   <= 1'b0;
                    end else begin
                        // first drain cycle only issues the read; valid follows it
                        valid_q  <= 1'b1;
                        rd_cnt_q <= rd_cnt_d;
                        last_q   <= (rd_cnt_d == 6'd63);
                    end
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

endmodule
